key_debouncer: RTL and testbench
================================

KEY_DEBOUNCER -- requirements
Module: key_debouncer

Interface
REQ-001 Parameter P_N_KEYS, default 2, number of independent key channels.
REQ-002 Parameter P_ICLK_COUNT, default 2**16, consecutive stable cycles required to accept a press or a release.
REQ-003 Parameter P_REPEAT_DELAY, default 2**24, held cycles before the first auto-repeat; 0 disables repeat.
REQ-004 Parameter P_REPEAT_RATE, default 2**22, cycles between subsequent auto-repeats; must be at least 1.
REQ-005 CLK1  in  1  sole clock, 50 MHz nominal.
REQ-006 RST  in  1  reset; one clock; reset is asynchronous and active-high.
REQ-007 KEY_N  in  P_N_KEYS  raw push-button inputs, active-low (0 = pressed), asynchronous to CLK1.
REQ-008 KEY_LEVEL  out  P_N_KEYS  debounced state, 1 = pressed.
REQ-009 PRESS  out  P_N_KEYS  one-cycle pulse on accepted press.
REQ-010 RELEASE  out  P_N_KEYS  one-cycle pulse on accepted release.
REQ-011 REPEAT  out  P_N_KEYS  one-cycle pulse per auto-repeat while held.

Function
REQ-012 Each KEY_N bit SHALL pass through a 2-flop synchronizer; flops reset to 1 (released).
REQ-013 Each channel SHALL run a 4-state FSM: IDLE, PRESS_CHK, HELD, REL_CHK; channels fully independent.
REQ-014 IDLE -> PRESS_CHK when synchronized key = 0; stability counter cleared on entry.
REQ-015 PRESS_CHK: counter increments each cycle key stays 0; key = 1 before count reaches P_ICLK_COUNT -> IDLE, no output change (glitch rejected).
REQ-016 PRESS_CHK -> HELD after P_ICLK_COUNT consecutive low cycles; PRESS = 1 for exactly that one cycle; KEY_LEVEL = 1 from the same cycle.
REQ-017 Press latency: KEY_N low and stable from clock edge k SHALL yield PRESS high in cycle k+2+P_ICLK_COUNT (2 synchronizer + count); release latency identical.
REQ-018 HELD -> REL_CHK when synchronized key = 1; REL_CHK -> HELD if key returns to 0 before P_ICLK_COUNT, repeat timer continues uninterrupted.
REQ-019 REL_CHK -> IDLE after P_ICLK_COUNT consecutive high cycles; RELEASE = 1 for one cycle; KEY_LEVEL = 0 from the same cycle.
REQ-020 Repeat timer cleared on entry to HELD; counts in HELD and REL_CHK; first REPEAT when count = P_REPEAT_DELAY, then every P_REPEAT_RATE cycles.
REQ-021 REPEAT SHALL never coincide with PRESS or RELEASE of the same channel; no REPEAT when P_REPEAT_DELAY = 0.
REQ-022 Stability counter width $clog2(P_ICLK_COUNT+1); repeat counter width sized for max(P_REPEAT_DELAY, P_REPEAT_RATE); counters saturate, never wrap.
REQ-023 All outputs registered; no combinational path from KEY_N to any output.

Reset
REQ-024 RST asserted: all FSMs to IDLE, all counters 0, synchronizer flops 1, KEY_LEVEL/PRESS/RELEASE/REPEAT = 0 immediately (asynchronous).
REQ-025 RST asserted while HELD SHALL not emit RELEASE; after deassertion a still-pressed key SHALL be re-qualified and yield a new PRESS after full latency.
REQ-026 RST deassertion is synchronized externally; block SHALL leave reset on the first CLK1 edge after deassertion.

Structure
REQ-027 Package key_debouncer_pkg SHALL hold the channel state enum (IDLE, PRESS_CHK, HELD, REL_CHK) and default constants for P_ICLK_COUNT, P_REPEAT_DELAY, P_REPEAT_RATE.
REQ-028 Single-channel logic SHALL be sub-module key_debounce_ch, instantiated P_N_KEYS times by a generate loop in key_debouncer.

Verification (bench uses P_ICLK_COUNT=16, P_REPEAT_DELAY=64, P_REPEAT_RATE=16, P_N_KEYS=2)
REQ-029 Clean press: KEY_N[0]=0 for 40 cycles then 1 -> PRESS[0] pulse at cycle 18 after first low edge, KEY_LEVEL[0]=1 cycles 18..57, RELEASE[0] pulse 18 cycles after return high, no REPEAT.
REQ-030 Glitch: KEY_N[0] low for 10 cycles then high -> PRESS, KEY_LEVEL, RELEASE all stay 0.
REQ-031 Bouncing release: hold 100 cycles, toggle KEY_N[0] high 5 / low 5 three times, then high -> exactly one RELEASE, KEY_LEVEL stays 1 during bounce.
REQ-032 Long hold: KEY_N[0] low 200 cycles -> one PRESS, REPEAT[0] at 64 cycles after PRESS then every 16 cycles (8 pulses total), one RELEASE.
REQ-033 Independence: KEY_N[0] and KEY_N[1] pressed 3 cycles apart -> PRESS[0] and PRESS[1] exactly 3 cycles apart, each single pulse.
REQ-034 Reset mid-hold: assert RST 5 cycles while KEY_LEVEL[0]=1, key still low -> outputs 0 at once, no RELEASE, new PRESS[0] 18 cycles after RST deasserted.

Source files
------------

// File: rtl/key_debouncer_pkg.sv
// -----------------------------------------------------------------------------
// key_debouncer_pkg
// Shared definitions for the key debouncer:
//   - ch_state_t      : per-channel debounce state
//   - DEF_*           : default timing constants (in CLK1 cycles)
//   - max_int()       : constant helper used to size the repeat counter
// -----------------------------------------------------------------------------
package key_debouncer_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,  // key released and stable
        PRESS_CHK = 2'd1,  // key went low, qualifying the press
        HELD      = 2'd2,  // press accepted, auto-repeat timer running
        REL_CHK   = 2'd3   // key went high, qualifying the release
    } ch_state_t;

    localparam int DEF_ICLK_COUNT   = 2**16;
    localparam int DEF_REPEAT_DELAY = 2**24;
    localparam int DEF_REPEAT_RATE  = 2**22;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// -----------------------------------------------------------------------------
// key_debounce_ch
// One debounced push-button channel: 2-flop synchronizer, 4-state qualify
// FSM and auto-repeat timer. All outputs are registered.
//
// Ports:
//   clk           in   clock
//   rst           in   asynchronous active-high reset
//   key_n         in   raw key, active-low, asynchronous to clk
//   key_level     out  debounced level, 1 = pressed
//   press         out  one-cycle pulse on accepted press
//   release_pulse out  one-cycle pulse on accepted release
//   repeat_pulse  out  one-cycle pulse per auto-repeat while held
//   state         out  current FSM state (observation only)
// -----------------------------------------------------------------------------
module key_debounce_ch
    import key_debouncer_pkg::*;
#(
    parameter int P_ICLK_COUNT   = DEF_ICLK_COUNT,
    parameter int P_REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int P_REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      key_n,
    output logic      key_level,
    output logic      press,
    output logic      release_pulse,
    output logic      repeat_pulse,
    output ch_state_t state
);

    localparam int STAB_W  = $clog2(P_ICLK_COUNT + 1);
    localparam int RPT_MAX = max_int(P_REPEAT_DELAY, P_REPEAT_RATE);
    localparam int RPT_W   = (RPT_MAX < 1) ? 1 : $clog2(RPT_MAX + 1);

    // The qualifying edge itself is the first stable cycle, so the counter
    // only has to advance to COUNT-1 before the transition fires.
    localparam logic [STAB_W-1:0] STAB_LAST       = STAB_W'(P_ICLK_COUNT - 1);
    localparam logic [RPT_W-1:0]  RPT_DELAY_LAST  = RPT_W'(P_REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0]  RPT_RATE_LAST   = RPT_W'(P_REPEAT_RATE - 1);
    localparam logic [RPT_W-1:0]  RPT_SAT         = {RPT_W{1'b1}};
    localparam logic              REPEAT_EN       = (P_REPEAT_DELAY > 0);

    logic [1:0]        sync_ff;     // [0] first stage, [1] synchronized key
    logic              key_s;
    logic [STAB_W-1:0] stab_cnt;
    logic [RPT_W-1:0]  rpt_cnt;
    logic              rpt_phase;   // 0: waiting for first repeat, 1: rate
    logic [RPT_W-1:0]  rpt_limit;
    logic              rpt_hit;
    logic              timer_run;

    assign key_s     = sync_ff[1];
    assign rpt_limit = rpt_phase ? RPT_RATE_LAST : RPT_DELAY_LAST;
    assign rpt_hit   = REPEAT_EN && (rpt_cnt >= rpt_limit);
    assign timer_run = (state == HELD) || (state == REL_CHK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_ff       <= 2'b11;
            state         <= IDLE;
            stab_cnt      <= '0;
            rpt_cnt       <= '0;
            rpt_phase     <= 1'b0;
            key_level     <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            sync_ff       <= {sync_ff[0], key_n};
            press         <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;

            // The repeat timer keeps its phase through release bounces, but a
            // pulse is only emitted while the key is genuinely held; a hit
            // that lands during release qualification is consumed silently.
            if (timer_run) begin
                if (rpt_hit) begin
                    rpt_cnt      <= '0;
                    rpt_phase    <= 1'b1;
                    repeat_pulse <= (state == HELD) && !key_s;
                end else if (rpt_cnt != RPT_SAT) begin
                    rpt_cnt <= rpt_cnt + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (!key_s) begin
                        state    <= PRESS_CHK;
                        stab_cnt <= '0;
                    end
                end
                PRESS_CHK: begin
                    if (key_s) begin
                        state <= IDLE;
                    end else if (stab_cnt >= STAB_LAST) begin
                        state     <= HELD;
                        press     <= 1'b1;
                        key_level <= 1'b1;
                        rpt_cnt   <= '0;
                        rpt_phase <= 1'b0;
                    end else begin
                        stab_cnt <= stab_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (key_s) begin
                        state    <= REL_CHK;
                        stab_cnt <= '0;
                    end
                end
                REL_CHK: begin
                    if (!key_s) begin
                        state <= HELD;
                    end else if (stab_cnt >= STAB_LAST) begin
                        state         <= IDLE;
                        release_pulse <= 1'b1;
                        key_level     <= 1'b0;
                    end else begin
                        stab_cnt <= stab_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/key_debouncer.sv
// -----------------------------------------------------------------------------
// key_debouncer
// P_N_KEYS independent debounced push-button channels with press/release
// pulses and auto-repeat.
//
// Ports:
//   CLK1      in   sole clock
//   RST       in   asynchronous active-high reset
//   KEY_N     in   raw keys, active-low, asynchronous to CLK1
//   KEY_LEVEL out  debounced state per key, 1 = pressed
//   PRESS     out  one-cycle pulse per accepted press
//   RELEASE   out  one-cycle pulse per accepted release
//   REPEAT    out  one-cycle pulse per auto-repeat while held
// -----------------------------------------------------------------------------
module key_debouncer
    import key_debouncer_pkg::*;
#(
    parameter int P_N_KEYS       = 2,
    parameter int P_ICLK_COUNT   = DEF_ICLK_COUNT,
    parameter int P_REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int P_REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic                CLK1,
    input  logic                RST,
    input  logic [P_N_KEYS-1:0] KEY_N,
    output logic [P_N_KEYS-1:0] KEY_LEVEL,
    output logic [P_N_KEYS-1:0] PRESS,
    output logic [P_N_KEYS-1:0] RELEASE,
    output logic [P_N_KEYS-1:0] REPEAT
);

    ch_state_t ch_state [P_N_KEYS];

    for (genvar gi = 0; gi < P_N_KEYS; gi++) begin : g_ch
        key_debounce_ch #(
            .P_ICLK_COUNT   (P_ICLK_COUNT),
            .P_REPEAT_DELAY (P_REPEAT_DELAY),
            .P_REPEAT_RATE  (P_REPEAT_RATE)
        ) u_ch (
            .clk           (CLK1),
            .rst           (RST),
            .key_n         (KEY_N[gi]),
            .key_level     (KEY_LEVEL[gi]),
            .press         (PRESS[gi]),
            .release_pulse (RELEASE[gi]),
            .repeat_pulse  (REPEAT[gi]),
            .state         (ch_state[gi])
        );
    end

endmodule

// File: tb/tb_key_debouncer.sv
// -----------------------------------------------------------------------------
// tb_key_debouncer
// Directed bench for key_debouncer with short timing parameters.
// Cycle index t = 0 is the first rising edge that samples the new key value.
// -----------------------------------------------------------------------------
module tb_key_debouncer;

    localparam int N_KEYS = 2;
    localparam int ICLK   = 16;
    localparam int RDELAY = 64;
    localparam int RRATE  = 16;

    logic              CLK1;
    logic              RST;
    logic [N_KEYS-1:0] KEY_N;
    logic [N_KEYS-1:0] KEY_LEVEL;
    logic [N_KEYS-1:0] PRESS;
    logic [N_KEYS-1:0] RELEASE;
    logic [N_KEYS-1:0] REPEAT;

    key_debouncer #(
        .P_N_KEYS       (N_KEYS),
        .P_ICLK_COUNT   (ICLK),
        .P_REPEAT_DELAY (RDELAY),
        .P_REPEAT_RATE  (RRATE)
    ) dut (
        .CLK1      (CLK1),
        .RST       (RST),
        .KEY_N     (KEY_N),
        .KEY_LEVEL (KEY_LEVEL),
        .PRESS     (PRESS),
        .RELEASE   (RELEASE),
        .REPEAT    (REPEAT)
    );

    // ---------------- clock ----------------
    initial CLK1 = 1'b0;
    always #5 CLK1 = ~CLK1;

    // ---------------- bookkeeping ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // ---------------- stimulus table ----------------
    typedef struct {
        int low_cycles;
        int exp_press;
        int exp_press_at;
        int exp_release;
        int exp_release_at;
        int exp_repeat;
        int exp_first_repeat;
    } vec_t;

    vec_t vecs [6];

    // observations from run_ch0
    int o_press_cnt, o_press_at, o_rel_cnt, o_rel_at;
    int o_rpt_cnt, o_rpt_first, o_spacing_err, o_overlap, o_level_err, o_ch1_err;

    // mode 0: low for 'low' cycles then high
    // mode 1: low for 'low' cycles, then high5/low5 x3, then high
    function automatic logic key_pattern(input int mode, input int low, input int t);
        if (t < low) return 1'b0;
        if (mode == 1 && t < low + 30) return (((t - low) / 5) % 2 == 0);
        return 1'b1;
    endfunction

    task automatic run_ch0(input int mode, input int low, input int cycles,
                           input int lvl_from, input int lvl_to);
        int prev_rpt;
        o_press_cnt = 0; o_press_at = -1; o_rel_cnt = 0; o_rel_at = -1;
        o_rpt_cnt = 0; o_rpt_first = -1; o_spacing_err = 0; o_overlap = 0;
        o_level_err = 0; o_ch1_err = 0; prev_rpt = -1;
        for (int t = 0; t < cycles; t++) begin
            @(negedge CLK1);
            KEY_N[0] = key_pattern(mode, low, t);
            @(posedge CLK1);
            #1;
            if (PRESS[0]) begin
                o_press_cnt++;
                if (o_press_at < 0) o_press_at = t;
            end
            if (RELEASE[0]) begin
                o_rel_cnt++;
                if (o_rel_at < 0) o_rel_at = t;
            end
            if (REPEAT[0]) begin
                o_rpt_cnt++;
                if (o_rpt_first < 0) o_rpt_first = t;
                if (prev_rpt >= 0 && (t - prev_rpt) != RRATE) o_spacing_err++;
                prev_rpt = t;
                if (PRESS[0] || RELEASE[0]) o_overlap++;
            end
            if (KEY_LEVEL[0] !== ((t >= lvl_from && t < lvl_to) ? 1'b1 : 1'b0)) o_level_err++;
            if (KEY_LEVEL[1] | PRESS[1] | RELEASE[1] | REPEAT[1]) o_ch1_err++;
        end
        KEY_N[0] = 1'b1;
    endtask

    // ---------------- main test ----------------
    initial begin
        int p0, p1, c0, c1, lvl, rel_cnt, press_at, press_cnt;

        //                low  prs at  rel at   rpt first
        vecs[0] = '{ 40,  1, 18,  1,  58,  0, -1 };  // clean press
        vecs[1] = '{ 10,  0, -1,  0,  -1,  0, -1 };  // glitch
        vecs[2] = '{ 16,  0, -1,  0,  -1,  0, -1 };  // one cycle short
        vecs[3] = '{ 17,  1, 18,  1,  35,  0, -1 };  // just long enough
        vecs[4] = '{ 100, 1, 18,  1, 118,  2, 82 };  // hit during REL_CHK is silent
        vecs[5] = '{ 200, 1, 18,  1, 218,  8, 82 };  // long hold

        KEY_N = '1;
        RST   = 1'b1;
        repeat (2) @(posedge CLK1);
        #1;
        chk("reset_key_level", int'(KEY_LEVEL), 0);
        chk("reset_press",     int'(PRESS),     0);
        chk("reset_release",   int'(RELEASE),   0);
        chk("reset_repeat",    int'(REPEAT),    0);
        @(negedge CLK1);
        RST = 1'b0;
        repeat (4) @(posedge CLK1);

        // table-driven single-key scenarios
        for (int i = 0; i < 6; i++) begin
            int lf, lt;
            lf = vecs[i].exp_press   ? vecs[i].exp_press_at   : -1;
            lt = vecs[i].exp_release ? vecs[i].exp_release_at : -1;
            run_ch0(0, vecs[i].low_cycles, vecs[i].low_cycles + 70, lf, lt);
            chk($sformatf("v%0d_press_cnt", i), o_press_cnt, vecs[i].exp_press);
            if (vecs[i].exp_press > 0)
                chk($sformatf("v%0d_press_at", i), o_press_at, vecs[i].exp_press_at);
            chk($sformatf("v%0d_release_cnt", i), o_rel_cnt, vecs[i].exp_release);
            if (vecs[i].exp_release > 0)
                chk($sformatf("v%0d_release_at", i), o_rel_at, vecs[i].exp_release_at);
            chk($sformatf("v%0d_repeat_cnt", i), o_rpt_cnt, vecs[i].exp_repeat);
            if (vecs[i].exp_repeat > 0)
                chk($sformatf("v%0d_first_repeat", i), o_rpt_first, vecs[i].exp_first_repeat);
            chk($sformatf("v%0d_repeat_spacing_err", i), o_spacing_err, 0);
            chk($sformatf("v%0d_repeat_overlap", i), o_overlap, 0);
            chk($sformatf("v%0d_level_err", i), o_level_err, 0);
            chk($sformatf("v%0d_ch1_activity", i), o_ch1_err, 0);
        end

        // bouncing release: last high edge at t=130, release qualified at 148
        run_ch0(1, 100, 200, 18, 148);
        chk("bounce_press_cnt",   o_press_cnt, 1);
        chk("bounce_release_cnt", o_rel_cnt,   1);
        chk("bounce_release_at",  o_rel_at,    148);
        chk("bounce_level_err",   o_level_err, 0);

        // independence: key1 goes low 3 cycles after key0
        p0 = -1; p1 = -1; c0 = 0; c1 = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge CLK1);
            KEY_N[0] = (t < 40) ? 1'b0 : 1'b1;
            KEY_N[1] = (t >= 3 && t < 43) ? 1'b0 : 1'b1;
            @(posedge CLK1);
            #1;
            if (PRESS[0]) begin c0++; if (p0 < 0) p0 = t; end
            if (PRESS[1]) begin c1++; if (p1 < 0) p1 = t; end
        end
        chk("indep_press0_cnt", c0, 1);
        chk("indep_press1_cnt", c1, 1);
        chk("indep_press0_at",  p0, 18);
        chk("indep_press_gap",  p1 - p0, 3);

        // reset while held: no RELEASE, re-qualified press after full latency
        lvl = 0;
        for (int t = 0; t < 40 && lvl == 0; t++) begin
            @(negedge CLK1);
            KEY_N[0] = 1'b0;
            @(posedge CLK1);
            #1;
            lvl = int'(KEY_LEVEL[0]);
        end
        chk("rst_hold_level_reached", lvl, 1);
        repeat (3) @(posedge CLK1);
        @(negedge CLK1);
        RST = 1'b1;
        #1;
        chk("rst_async_key_level", int'(KEY_LEVEL), 0);
        chk("rst_async_pulses", int'(PRESS | RELEASE | REPEAT), 0);
        rel_cnt = 0;
        for (int t = 0; t < 5; t++) begin
            @(posedge CLK1);
            #1;
            if (RELEASE[0]) rel_cnt++;
        end
        @(negedge CLK1);
        RST = 1'b0;
        press_at = -1; press_cnt = 0;
        for (int t = 0; t < 40; t++) begin
            @(posedge CLK1);
            #1;
            if (RELEASE[0]) rel_cnt++;
            if (PRESS[0]) begin press_cnt++; if (press_at < 0) press_at = t; end
        end
        chk("rst_no_release",  rel_cnt,   0);
        chk("rst_press_cnt",   press_cnt, 1);
        chk("rst_press_at",    press_at,  18);
        @(negedge CLK1);
        KEY_N[0] = 1'b1;
        repeat (40) @(posedge CLK1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
